// File: rtl/alu_types.sv
// Shared ALU types: operation tag, result flags and result buffer depth.
package alu_types;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd3,
        ALU_SLT = 4'd4,
        ALU_NOR = 4'd5,
        ALU_XOR = 4'd6,
        ALU_SLL = 4'd7
    } alu_control_t;

    typedef struct packed {
        logic overflow;
        logic zero;
        logic equal;
    } alu_flags_t;

    localparam int ALU_RB_DEPTH = 2;

endpackage

// File: rtl/alu_result_buffer.sv
// Two-entry skid buffer registering ALU results, flags and tag for the next stage.
// Optional per-entry parity output enabled by ALU_RESULT_BUFFER_PARITY_EN.
module alu_result_buffer
    import alu_types::*;
#(
    parameter int N  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  alu_control_t  in_control,
    input  logic [N-1:0]  in_result,
    input  logic          in_overflow,
    input  logic          in_zero,
    input  logic          in_equal,
    output logic          out_valid,
    input  logic          out_ready,
    output alu_control_t  out_control,
    output logic [N-1:0]  out_result,
    output alu_flags_t    out_flags,
    output logic          sticky_overflow,
    input  logic          clear_sticky,
`ifdef ALU_RESULT_BUFFER_PARITY_EN
    output logic          out_parity,
`endif
    output logic [CW-1:0] op_count
);

    logic [N-1:0] result_q  [ALU_RB_DEPTH];
    alu_control_t control_q [ALU_RB_DEPTH];
    alu_flags_t   flags_q   [ALU_RB_DEPTH];
`ifdef ALU_RESULT_BUFFER_PARITY_EN
    logic         parity_q  [ALU_RB_DEPTH];
`endif
    logic         head;
    logic         tail;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    // in_ready is qualified by rst_n so the ALU sees "not ready" throughout reset
    assign in_ready  = rst_n && (count != 2'(ALU_RB_DEPTH));
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_result  = result_q[head];
    assign out_control = control_q[head];
    assign out_flags   = flags_q[head];
`ifdef ALU_RESULT_BUFFER_PARITY_EN
    assign out_parity  = parity_q[head];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ALU_RB_DEPTH; i++) begin
                result_q[i]  <= '0;
                control_q[i] <= ALU_AND;
                flags_q[i]   <= '0;
`ifdef ALU_RESULT_BUFFER_PARITY_EN
                parity_q[i]  <= 1'b0;
`endif
            end
            head            <= 1'b0;
            tail            <= 1'b0;
            count           <= 2'd0;
            sticky_overflow <= 1'b0;
            op_count        <= '0;
        end else begin
            if (push) begin
                result_q[tail]  <= in_result;
                control_q[tail] <= in_control;
                flags_q[tail]   <= '{overflow: in_overflow, zero: in_zero, equal: in_equal};
`ifdef ALU_RESULT_BUFFER_PARITY_EN
                parity_q[tail]  <= ^in_result;
`endif
                tail            <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            // a new overflow outranks a simultaneous clear
            if (push && in_overflow) begin
                sticky_overflow <= 1'b1;
            end else if (clear_sticky) begin
                sticky_overflow <= 1'b0;
            end

            if (push && (op_count != {CW{1'b1}})) begin
                op_count <= op_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized self-checking bench for alu_result_buffer against a queue-based model.
// Built with CW = 4 so op_count saturation is reachable quickly.
module tb_alu_result_buffer;
    import alu_types::*;

    localparam int N   = 32;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    alu_control_t  in_control = ALU_AND;
    logic [N-1:0]  in_result = '0;
    logic          in_overflow = 1'b0;
    logic          in_zero = 1'b0;
    logic          in_equal = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    alu_control_t  out_control;
    logic [N-1:0]  out_result;
    alu_flags_t    out_flags;
    logic          sticky_overflow;
    logic          clear_sticky = 1'b0;
    logic [CW-1:0] op_count;
`ifdef ALU_RESULT_BUFFER_PARITY_EN
    logic          out_parity;
`endif

    alu_result_buffer #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_control(in_control),
        .in_result(in_result), .in_overflow(in_overflow), .in_zero(in_zero),
        .in_equal(in_equal), .out_valid(out_valid), .out_ready(out_ready),
        .out_control(out_control), .out_result(out_result), .out_flags(out_flags),
        .sticky_overflow(sticky_overflow), .clear_sticky(clear_sticky),
`ifdef ALU_RESULT_BUFFER_PARITY_EN
        .out_parity(out_parity),
`endif
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: FIFO contents, sticky bit and accepted-op total
    logic [N-1:0] m_res [$];
    logic [3:0]   m_ctl [$];
    logic [2:0]   m_flg [$];
    bit           m_sticky = 0;
    int           m_ops = 0;

    function automatic void model_reset();
        m_res.delete(); m_ctl.delete(); m_flg.delete();
        m_sticky = 0;
        m_ops = 0;
    endfunction

    // drive one clock of stimulus starting just after a negedge, update model at the posedge
    task automatic drive_cycle(input bit iv, input bit ordy, input bit clr,
                               input alu_control_t ctl, input logic [N-1:0] res,
                               input bit ovf, input bit zr, input bit eq,
                               output bit pushed);
        bit do_push, do_pop;
        in_valid = iv; out_ready = ordy; clear_sticky = clr;
        in_control = ctl; in_result = res;
        in_overflow = ovf; in_zero = zr; in_equal = eq;
        do_push = iv && (m_res.size() < ALU_RB_DEPTH);
        do_pop  = ordy && (m_res.size() > 0);
        @(posedge clk);
        if (do_pop) begin
            void'(m_res.pop_front()); void'(m_ctl.pop_front()); void'(m_flg.pop_front());
        end
        if (do_push) begin
            m_res.push_back(res); m_ctl.push_back(4'(ctl)); m_flg.push_back({ovf, zr, eq});
            m_ops = (m_ops + 1 > SAT) ? SAT : m_ops + 1;
        end
        if (do_push && ovf) m_sticky = 1;
        else if (clr) m_sticky = 0;
        pushed = do_push;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; clear_sticky = 1'b0; in_overflow = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || op_count !== '0 || sticky_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: valid=%b ready=%b cnt=%0d sticky=%b, required 0 0 0 0",
                     out_valid, in_ready, op_count, sticky_overflow);
        end
        checks++;
        if (out_result !== '0 || out_flags !== 3'b000 || out_control !== ALU_AND) begin
            errors++;
            $display("FAIL reset_head: result=%h flags=%b ctl=%0d, required 0 0 0",
                     out_result, out_flags, out_control);
        end
`ifdef ALU_RESULT_BUFFER_PARITY_EN
        checks++;
        if (out_parity !== 1'b0) begin
            errors++;
            $display("FAIL reset_parity: got %b required 0", out_parity);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b required 1", in_ready);
        end
    endtask

    task automatic test_single();
        bit p;
        drive_cycle(1, 0, 0, ALU_ADD, 32'h0000_0005, 0, 0, 0, p);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h5 || op_count !== 4'd1) begin
            errors++;
            $display("FAIL single_push: valid=%b result=%h cnt=%0d, required 1 5 1",
                     out_valid, out_result, op_count);
        end
        checks++;
        if (out_control !== ALU_ADD || out_flags !== 3'b000) begin
            errors++;
            $display("FAIL single_tag: ctl=%0d flags=%b, required %0d 000", out_control, out_flags, ALU_ADD);
        end
        drive_cycle(0, 1, 0, ALU_AND, '0, 0, 0, 0, p);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_full_backpressure();
        bit p;
        bit got3 = 0;
        logic [N-1:0] want [3];
        want[0] = 32'h1; want[1] = 32'h2; want[2] = 32'h3;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, 0, 0, ALU_OR, want[i], 0, 0, 0, p);
            if (i == 2) got3 = p;
            checks++;
            if (in_ready !== (i == 0)) begin
                errors++;
                $display("FAIL full_ready_%0d: got %b required %b", i, in_ready, (i == 0));
            end
        end
        checks++;
        if (got3 !== 1'b0 || out_result !== 32'h1) begin
            errors++;
            $display("FAIL full_hold: third_accepted=%b head=%h, required 0 1", got3, out_result);
        end
        // ALU keeps offering 0x3 while the consumer drains
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== want[k]) begin
                errors++;
                $display("FAIL drain_%0d: valid=%b result=%h, required 1 %h", k, out_valid, out_result, want[k]);
            end
            drive_cycle(!got3, 1, 0, ALU_OR, 32'h3, 0, 0, 0, p);
            if (p) got3 = 1;
        end
        checks++;
        if (out_valid !== 1'b0 || m_res.size() != 0) begin
            errors++;
            $display("FAIL drain_empty: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit p;
        logic [N-1:0] seq [10];
        for (int i = 0; i < 10; i++) seq[i] = $urandom;
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== seq[i-1] || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_%0d: valid=%b result=%h ready=%b, required 1 %h 1",
                             i, out_valid, out_result, in_ready, seq[i-1]);
                end
            end
            drive_cycle(i < 10, 1, 0, ALU_XOR, (i < 10) ? seq[i] : '0, 0, 0, 0, p);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_sticky();
        bit p;
        logic [N-1:0] a = 32'h7FFF_FFFF;
        logic [N-1:0] b = 32'h0000_0001;
        logic [N-1:0] sum = a + b;
        drive_cycle(1, 1, 0, ALU_ADD, sum, 1, 0, 0, p);
        checks++;
        if (sticky_overflow !== 1'b1 || out_result !== 32'h8000_0000 || out_flags.overflow !== 1'b1) begin
            errors++;
            $display("FAIL sticky_set: sticky=%b result=%h ovf=%b, required 1 80000000 1",
                     sticky_overflow, out_result, out_flags.overflow);
        end
        drive_cycle(1, 1, 1, ALU_ADD, sum, 1, 0, 0, p);
        checks++;
        if (sticky_overflow !== 1'b1) begin
            errors++;
            $display("FAIL sticky_set_wins: got %b required 1", sticky_overflow);
        end
        drive_cycle(0, 1, 1, ALU_AND, '0, 0, 0, 0, p);
        checks++;
        if (sticky_overflow !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear: got %b required 0", sticky_overflow);
        end
    endtask

    task automatic test_saturation();
        bit p;
        for (int i = 0; i < 17; i++) begin
            drive_cycle(1, 1, 0, ALU_SUB, $urandom, 0, 0, 0, p);
            checks++;
            if (op_count !== CW'(m_ops)) begin
                errors++;
                $display("FAIL op_count_%0d: got %0d required %0d", i, op_count, m_ops);
            end
        end
        checks++;
        if (op_count !== 4'd15) begin
            errors++;
            $display("FAIL op_count_sat: got %0d required 15", op_count);
        end
        drive_cycle(0, 1, 0, ALU_AND, '0, 0, 0, 0, p);
    endtask

    task automatic test_random();
        bit p;
        logic [N-1:0] r;
        for (int i = 0; i < 300; i++) begin
            checks++;
            if (out_valid !== (m_res.size() != 0) || in_ready !== (m_res.size() < 2) ||
                sticky_overflow !== m_sticky || op_count !== CW'(m_ops)) begin
                errors++;
                $display("FAIL rand_status_%0d: valid=%b ready=%b sticky=%b cnt=%0d, required %b %b %b %0d",
                         i, out_valid, in_ready, sticky_overflow, op_count,
                         (m_res.size() != 0), (m_res.size() < 2), m_sticky, m_ops);
            end
            if (m_res.size() != 0) begin
                checks++;
                if (out_result !== m_res[0] || 4'(out_control) !== m_ctl[0] || out_flags !== m_flg[0]) begin
                    errors++;
                    $display("FAIL rand_head_%0d: result=%h ctl=%0d flags=%b, required %h %0d %b",
                             i, out_result, out_control, out_flags, m_res[0], m_ctl[0], m_flg[0]);
                end
`ifdef ALU_RESULT_BUFFER_PARITY_EN
                checks++;
                if (out_parity !== ^m_res[0]) begin
                    errors++;
                    $display("FAIL rand_parity_%0d: got %b required %b", i, out_parity, ^m_res[0]);
                end
`endif
            end
            r = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                        alu_control_t'($urandom_range(0, 7)), r,
                        $urandom_range(0, 9) == 0, r == '0, $urandom_range(0, 1) == 1, p);
        end
    endtask

    task automatic test_async_reset();
        bit p;
        drive_cycle(0, 1, 0, ALU_AND, '0, 0, 0, 0, p);
        drive_cycle(0, 1, 0, ALU_AND, '0, 0, 0, 0, p);
        drive_cycle(1, 0, 0, ALU_ADD, 32'hAAAA_0001, 1, 0, 0, p);
        drive_cycle(1, 0, 0, ALU_ADD, 32'hAAAA_0002, 0, 0, 1, p);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || sticky_overflow !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_full: ready=%b valid=%b sticky=%b, required 0 1 1",
                     in_ready, out_valid, sticky_overflow);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || op_count !== '0 || sticky_overflow !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b cnt=%0d sticky=%b ready=%b, required 0 0 0 0",
                     out_valid, op_count, sticky_overflow, in_ready);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_cycle(1, 0, 0, ALU_SLT, 32'h1234_5678, 0, 0, 0, p);
        checks++;
        if (out_result !== 32'h1234_5678 || op_count !== 4'd1) begin
            errors++;
            $display("FAIL post_reset_push: result=%h cnt=%0d, required 12345678 1", out_result, op_count);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_full_backpressure();
        test_back_to_back();
        test_sticky();
        test_saturation();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Registered output stage directly downstream of the 32-bit combinational ALU.
- Captures each ALU result, its flags (overflow, zero, equal) and the alu_control_t tag into a 2-entry skid buffer.
- Presents captured entries to the next stage (writeback/branch logic) over a valid/ready handshake.
- Maintains a sticky overflow status bit and a saturating count of accepted operations.

Parameters:
- N, 32, data width of result (only 32 is required).
- CW, 16, width of op_count.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  ALU output is valid this cycle.
- in_ready  output  1  buffer can accept an entry.
- in_control  input  alu_control_t  operation that produced the result.
- in_result  input  N  ALU result.
- in_overflow  input  1  ALU overflow flag.
- in_zero  input  1  ALU zero flag.
- in_equal  input  1  ALU equal flag.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes head entry.
- out_control  output  alu_control_t  head entry tag.
- out_result  output  N  head entry result.
- out_flags  output  alu_flags_t  head entry {overflow, zero, equal}.
- sticky_overflow  output  1  set by any accepted entry with overflow = 1.
- clear_sticky  input  1  synchronous clear of sticky_overflow.
- op_count  output  CW  number of accepted entries, saturating.

Behaviour:
- Reset is asynchronous, active-low, one clock domain.
- While rst_n = 0:
  - count = 0 and both entries are cleared.
  - out_valid = 0; out_result, out_flags and out_control = 0 (control = first enum value).
  - sticky_overflow = 0 and op_count = 0.
  - in_ready = 0, because in_ready = rst_n && (count != 2).
- Push is in_valid && in_ready. Pop is out_valid && out_ready.
- Storage is a 2-entry FIFO, head/tail pointer pair, count 0..2.
- out_valid = (count != 0). out_* are driven from the head entry register only; there is no combinational path from in_* to out_*.
- Latency: an entry pushed at edge t is visible on out_* after edge t, provided the buffer was empty. Throughput is 1 entry/cycle when out_ready is held high.
- Count transitions:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together (count 1): count stays 1 and the new entry becomes head on the next cycle.
  - Push and pop together with count 0 is impossible, since out_valid = 0.
- Full (count = 2): in_ready = 0; in_valid is ignored and the ALU side must hold its values.
- Empty: out_ready is ignored and the head does not change.
- Pointers wrap modulo 2.
- Head stability: head contents are stable while out_valid && !out_ready.
- sticky_overflow:
  - Set on any push with in_overflow = 1.
  - Cleared by clear_sticky.
  - Set wins if both happen in the same cycle.
- op_count increments on each push and saturates at 2^CW - 1; it never wraps.
- Reset mid-operation discards all stored entries immediately.

Optional Feature:
- Macro: ALU_RESULT_BUFFER_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit), the even parity (XOR-reduce) of in_result computed at push and stored per entry.
  - out_parity is 0 in reset and follows the head entry.
- Undefined: the port and its storage are absent, and all other behaviour is identical.

Decomposition:
- In the alu_types package:
  - Add alu_flags_t, a packed struct {overflow, zero, equal}.
  - Reuse alu_control_t.
  - Add localparam ALU_RB_DEPTH = 2.
- No sub-module is required. The saturating counter is inline; a 2-entry FIFO sub-module is not justified.

Test Plan:
- Reset, then push in_result = 32'h0000_0005 with flags 0,0,0: out_valid rises one cycle later with out_result = 5; op_count = 1.
- Hold out_ready = 0 and push 3 entries (0x1, 0x2, 0x3):
  - in_ready drops after the second push.
  - The third entry is held off.
  - Raising out_ready drains 0x1, 0x2, then 0x3 in order.
- Stream 10 entries with in_valid = out_ready = 1 continuously: 10 pops in 10 consecutive cycles, order preserved, count never exceeds 1.
- Push with in_overflow = 1 (a = 32'h7FFF_FFFF, b = 1, ADD result 32'h8000_0000):
  - sticky_overflow = 1.
  - A clear_sticky asserted in the same cycle as another overflow push leaves sticky_overflow = 1.
  - clear_sticky alone then clears it.
- Force op_count near saturation (CW = 4, 17 pushes): op_count stops at 15.
- Assert rst_n = 0 mid-cycle while count = 2: out_valid, op_count and sticky_overflow go to 0 immediately, without waiting for a clock edge.
